// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative restoring divider for the EX stage (DIV / DIVU).
//             Performs one restoring step per clock and returns
//             {remainder, quotient} for the HI/LO write. While a divide is
//             in flight, stallreq_o holds the front of the pipeline.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             start_i           - divide request, held until ready_o
//             signed_i          - 1 = DIV (two's complement), 0 = DIVU
//             opdata1_i/2_i     - dividend / divisor
//             annul_i           - cancel the operation in flight
//             result_o          - {remainder, quotient}
//             ready_o           - result_o valid
//             stallreq_o        - start_i & ~ready_o & ~annul_i
//  Revision : 1.0 - initial release
// ============================================================================
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam logic [5:0] CNT_LAST = 6'(DATA_W);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  // {partial remainder (W+1 bits), dividend bits shifting out / quotient bits shifting in}
  logic [2*DATA_W:0]     work_q, work_d;
  logic [DATA_W-1:0]     dvsr_q, dvsr_d;
  logic                  qsign_q, qsign_d;
  logic                  rsign_q, rsign_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  // Operand magnitudes, negated only for signed negative operands.
  logic                  neg1, neg2;
  logic [DATA_W-1:0]     abs1, abs2;
  assign neg1 = signed_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_i & opdata2_i[DATA_W-1];
  assign abs1 = neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
  assign abs2 = neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

  // One restoring step: shift left, then trial-subtract the divisor from the
  // upper W+1 bits. The extra MSB of the trial is its sign.
  logic [2*DATA_W:0]     shifted;
  logic [DATA_W+1:0]     trial;
  assign shifted = work_q << 1;
  assign trial   = {1'b0, shifted[2*DATA_W:DATA_W]} - {2'b00, dvsr_q};

  // Sign fix-up of the finished magnitudes.
  logic [DATA_W-1:0]     quo_mag, rem_mag, quo_fix, rem_fix;
  assign quo_mag = work_q[DATA_W-1:0];
  assign rem_mag = work_q[2*DATA_W-1:DATA_W];
  assign quo_fix = qsign_q ? (~quo_mag + 1'b1) : quo_mag;
  assign rem_fix = rsign_q ? (~rem_mag + 1'b1) : rem_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    ready_d  = ready_q;

    if (annul_i) begin
      // Annul beats start in every state; no result is produced.
      state_d = S_IDLE;
      ready_d = 1'b0;
      cnt_d   = 6'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state_d = S_DIVZERO;
            end else begin
              work_d  = {{(DATA_W+1){1'b0}}, abs1};
              dvsr_d  = abs2;
              qsign_d = neg1 ^ neg2;
              rsign_d = neg1;
              cnt_d   = 6'd0;
              state_d = S_ON;
            end
          end
        end
        S_DIVZERO: begin
          result_d = '0;
          ready_d  = 1'b1;
          state_d  = S_END;
        end
        S_ON: begin
          if (cnt_q < CNT_LAST) begin
            if (!trial[DATA_W+1]) begin
              work_d = {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};
            end else begin
              work_d = {shifted[2*DATA_W:1], 1'b0};
            end
            cnt_d = cnt_q + 6'd1;
          end else begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = S_END;
          end
        end
        S_END: begin
          // Hold the result while EX is frozen with start_i still high.
          if (!start_i) begin
            ready_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      work_q   <= '0;
      dvsr_q   <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_iter
//  Purpose  : Directed self-checking bench for div_iter: unsigned/signed
//             divides, divide by zero, overflow, annul, END hold and reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_iter #(.DATA_W(32)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .opdata1_i  (opdata1_i),
    .opdata2_i  (opdata2_i),
    .annul_i    (annul_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .stallreq_o (stallreq_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance to the start of the next cycle (just after the active edge).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Launches a divide at the start of the current cycle (cycle 0), waits for
  // ready_o with a bound, checks latency, stall cycles and result, holds
  // start_i for hold_cyc extra cycles, then releases it.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res,
                         input int exp_cyc, input int hold_cyc);
    int rdy    = -1;
    int stalls = 0;
    int c      = 0;
    start_i   = 1'b1;
    signed_i  = sgn;
    opdata1_i = a;
    opdata2_i = b;
    while (rdy < 0 && c < 60) begin
      @(negedge clk);
      if (stallreq_o) stalls++;
      if (ready_o) begin
        rdy = c;
      end else begin
        next_cycle();
        if (c == 0) begin
          // Operands must be ignored once accepted.
          opdata1_i = $urandom;
          opdata2_i = $urandom | 32'h1;
          signed_i  = ~signed_i;
        end
        c++;
      end
    end
    check_eq({tag, "_ready_cycle"}, 64'(rdy), 64'(exp_cyc));
    check_eq({tag, "_stall_cycles"}, 64'(stalls), 64'(exp_cyc));
    check_eq({tag, "_result"}, result_o, exp_res);
    for (int h = 0; h < hold_cyc; h++) begin
      next_cycle();
      @(negedge clk);
      check_eq({tag, "_hold_ready"}, 64'(ready_o), 64'd1);
      check_eq({tag, "_hold_result"}, result_o, exp_res);
    end
    next_cycle();
    start_i = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
    check_eq({tag, "_result_kept"}, result_o, exp_res);
    next_cycle();
  endtask

  initial begin
    int seen_ready;
    rst       = 1'b1;
    start_i   = 1'b0;
    signed_i  = 1'b0;
    annul_i   = 1'b0;
    opdata1_i = '0;
    opdata2_i = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    check_eq("reset_result", result_o, 64'd0);
    check_eq("reset_ready", 64'(ready_o), 64'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    run_div("divu_100_7",  1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                 34, 5);
    run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34, 0);
    run_div("div_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},         34, 0);
    run_div("div_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  {32'hFFFF_FFFE, 32'd2},         34, 0);
    run_div("divu_big",    1'b0, 32'hFFFF_FFFF,  32'h10,         {32'hF, 32'h0FFF_FFFF},         34, 0);
    run_div("divu_5_0",    1'b0, 32'd5,          32'd0,          64'd0,                          2,  0);
    run_div("div_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0, 32'h8000_0000},         34, 0);

    // Annul in cycle 10 of a divide, then a fresh divide from cycle 12.
    seen_ready = 0;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ready_o) seen_ready = 1;
      next_cycle();
    end
    annul_i = 1'b1;
    @(negedge clk);
    check_eq("annul_stall_low", 64'(stallreq_o), 64'd0);
    next_cycle();
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    if (ready_o) seen_ready = 1;
    check_eq("annul_no_ready", 64'(seen_ready), 64'd0);
    next_cycle();
    run_div("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 34, 0);

    // Reset pulse in cycle 20 of a divide.
    seen_ready = 0;
    start_i   = 1'b1;
    signed_i  = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ready_o) seen_ready = 1;
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst     = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_result", result_o, 64'd0);
    check_eq("rst_mid_ready", 64'(ready_o), 64'd0);
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      @(negedge clk);
      if (ready_o) seen_ready = 1;
    end
    check_eq("rst_mid_no_ready", 64'(seen_ready), 64'd0);
    next_cycle();

    run_div("divu_after_rst", 1'b0, 32'd50, 32'd8, {32'd2, 32'd6}, 34, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
